// File: rtl/hier_seq_pkg.sv
// rtl/hier_seq_pkg.sv - shared types and helpers for the hierarchy fan-out sequencer
package hier_seq_pkg;

    localparam int MAX_CHILDREN = 32;
    localparam int MAX_IDX_W    = 5;

    typedef enum logic [1:0] {
        IDLE,
        DISPATCH,
        WAIT,
        FINISH
    } state_e;

    typedef enum logic {
        MODE_SEQ,
        MODE_PAR
    } mode_e;

    typedef struct packed {
        logic                 valid;
        logic [MAX_IDX_W-1:0] idx;
    } lowest_t;

    // Index of the lowest set bit; valid=0 when the mask is empty.
    function automatic lowest_t lowest_set(input logic [MAX_CHILDREN-1:0] mask);
        lowest_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = MAX_CHILDREN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                r.valid = 1'b1;
                r.idx   = MAX_IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/hier_seq_timeout.sv
// rtl/hier_seq_timeout.sv - loadable down-counter flagging expiry of one wait
module hier_seq_timeout
    import hier_seq_pkg::*;
#(
    parameter int TMO_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TMO_W-1:0] value,
    input  logic             run,
    output logic             expired
);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;

    // Load on dispatch, count down while waiting; a zero count stays parked and never expires.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The last counting cycle is the one where the count is about to reach zero.
    assign expired = run && !load && (cnt_q == TMO_W'(1));

endmodule

// File: rtl/hier_fanout_sequencer.sv
// rtl/hier_fanout_sequencer.sv - root controller dispatching start pulses to child instances
module hier_fanout_sequencer
    import hier_seq_pkg::*;
#(
    parameter int NUM_CHILDREN = 5,
    parameter int IDX_W        = $clog2(NUM_CHILDREN > 1 ? NUM_CHILDREN : 2),
    parameter int TMO_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    mode_i,
    input  logic [NUM_CHILDREN-1:0] enable_mask_i,
    input  logic [TMO_W-1:0]        timeout_i,
    output logic [NUM_CHILDREN-1:0] child_start_o,
    input  logic [NUM_CHILDREN-1:0] child_done_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [IDX_W-1:0]        fail_idx_o,
    output logic [NUM_CHILDREN-1:0] done_mask_o
);

    localparam logic [NUM_CHILDREN-1:0] ONE = NUM_CHILDREN'(1);

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    logic [NUM_CHILDREN-1:0] pend_q, pend_d;
    logic [NUM_CHILDREN-1:0] dmask_q, dmask_d;
    logic [NUM_CHILDREN-1:0] start_q, start_d;
    logic [IDX_W-1:0]        cur_q, cur_d;
    logic [IDX_W-1:0]        fidx_q, fidx_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic [NUM_CHILDREN-1:0] active;
    logic [NUM_CHILDREN-1:0] counted;
    logic [NUM_CHILDREN-1:0] pend_next;
    logic                    wait_complete;
    logic                    tmo_expired;
    lowest_t                 pick_left;
    lowest_t                 pick_next;

    hier_seq_timeout #(
        .TMO_W (TMO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (state_q == DISPATCH),
        .value   (tmo_q),
        .run     (state_q == WAIT),
        .expired (tmo_expired)
    );

    // Next-state logic: dispatch bookkeeping, done collection and timeout handling.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pend_d  = pend_q;
        dmask_d = dmask_q;
        cur_d   = cur_q;
        fidx_d  = fidx_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        done_d  = 1'b0;

        // Only children that were actually started and are still outstanding may complete.
        active        = (mode_q == MODE_PAR) ? pend_q : (ONE << cur_q);
        counted       = (state_q == WAIT) ? (child_done_i & active) : '0;
        pend_next     = pend_q & ~counted;
        wait_complete = (mode_q == MODE_PAR) ? (pend_next == '0) : (counted != '0);
        pick_left     = lowest_set(32'(pend_next));

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mode_d  = mode_e'(mode_i);
                    pend_d  = enable_mask_i;
                    tmo_d   = timeout_i;
                    dmask_d = '0;
                    err_d   = 1'b0;
                    fidx_d  = '0;
                    state_d = (enable_mask_i == '0) ? FINISH : DISPATCH;
                end
            end
            DISPATCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                pend_d  = pend_next;
                dmask_d = dmask_q | counted;
                // A done landing on the expiry cycle still completes the wait.
                if (wait_complete) begin
                    state_d = (pend_next == '0) ? FINISH : DISPATCH;
                end else if (tmo_expired) begin
                    err_d   = 1'b1;
                    fidx_d  = (mode_q == MODE_PAR && pick_left.valid) ? IDX_W'(pick_left.idx) : cur_q;
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Start pulses are registered so they appear during the DISPATCH cycle itself.
        pick_next = lowest_set(32'(pend_d));
        start_d   = '0;
        if (state_d == DISPATCH) begin
            if (mode_d == MODE_PAR) begin
                start_d = pend_d;
            end else if (pick_next.valid) begin
                start_d = ONE << pick_next.idx;
                cur_d   = IDX_W'(pick_next.idx);
            end
        end
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= MODE_SEQ;
            pend_q  <= '0;
            dmask_q <= '0;
            start_q <= '0;
            cur_q   <= '0;
            fidx_q  <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pend_q  <= pend_d;
            dmask_q <= dmask_d;
            start_q <= start_d;
            cur_q   <= cur_d;
            fidx_q  <= fidx_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign child_start_o = start_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign error_o       = err_q;
    assign fail_idx_o    = fidx_q;
    assign done_mask_o   = dmask_q;

endmodule

// File: tb/tb_hier_fanout_sequencer.sv
// tb/tb_hier_fanout_sequencer.sv - randomized self-checking bench for hier_fanout_sequencer
module tb_hier_fanout_sequencer;

    localparam int NC    = 5;
    localparam int IW    = 3;
    localparam int TW    = 8;
    localparam int NEVER = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic          mode_i = 1'b0;
    logic [NC-1:0] enable_mask_i = '0;
    logic [TW-1:0] timeout_i = '0;
    logic [NC-1:0] child_start_o;
    logic [NC-1:0] child_done_i = '0;
    logic          busy_o;
    logic          done_o;
    logic          error_o;
    logic [IW-1:0] fail_idx_o;
    logic [NC-1:0] done_mask_o;

    int checks = 0;
    int errors = 0;

    hier_fanout_sequencer #(
        .NUM_CHILDREN (NC),
        .TMO_W        (TW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .mode_i        (mode_i),
        .enable_mask_i (enable_mask_i),
        .timeout_i     (timeout_i),
        .child_start_o (child_start_o),
        .child_done_i  (child_done_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .error_o       (error_o),
        .fail_idx_o    (fail_idx_o),
        .done_mask_o   (done_mask_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start"}, child_start_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_error"}, error_o, 0);
        check({tag, "_fidx"}, fail_idx_o, 0);
        check({tag, "_dmask"}, done_mask_o, 0);
    endtask

    // One run: the reference outcome is derived from the timing rules, then the DUT is driven
    // cycle by cycle with children answering dly[j] cycles after their start pulse.
    task automatic run_case(input string tag, input bit mode, input logic [NC-1:0] mask,
                            input logic [TW-1:0] tmo, input int dly[NC],
                            input logic [NC-1:0] spur, input bit busy_start);
        int            exp_st[NC];
        int            obs_st[NC];
        int            npulse[NC];
        int            exp_done;
        logic [NC-1:0] exp_mask;
        bit            exp_err;
        int            exp_fidx;
        int            t;
        int            maxd;
        int            done_cyc;

        for (int j = 0; j < NC; j++) begin
            exp_st[j] = -1;
            obs_st[j] = -1;
            npulse[j] = 0;
        end
        exp_mask = '0;
        exp_err  = 1'b0;
        exp_fidx = 0;
        exp_done = 0;

        if (!mode) begin
            t = 1;
            for (int k = 0; k < NC; k++) begin
                if (mask[k] && !exp_err) begin
                    exp_st[k] = t;
                    if (tmo != 0 && dly[k] > int'(tmo)) begin
                        exp_err  = 1'b1;
                        exp_fidx = k;
                        exp_done = t + int'(tmo) + 2;
                    end else begin
                        exp_mask[k] = 1'b1;
                        t = t + dly[k] + 1;
                    end
                end
            end
            if (!exp_err) exp_done = t + 1;
        end else begin
            maxd = 0;
            for (int k = 0; k < NC; k++) begin
                if (mask[k]) begin
                    exp_st[k] = 1;
                    if (tmo == 0 || dly[k] <= int'(tmo)) begin
                        exp_mask[k] = 1'b1;
                        if (dly[k] > maxd) maxd = dly[k];
                    end else if (!exp_err) begin
                        exp_err  = 1'b1;
                        exp_fidx = k;
                    end
                end
            end
            if (mask == '0)   exp_done = 2;
            else if (exp_err) exp_done = int'(tmo) + 3;
            else              exp_done = maxd + 3;
        end

        @(negedge clk);
        start_i       = 1'b1;
        mode_i        = mode;
        enable_mask_i = mask;
        timeout_i     = tmo;
        child_done_i  = '0;
        done_cyc      = -1;

        for (int c = 1; c <= 400 && done_cyc < 0; c++) begin
            @(negedge clk);
            start_i = busy_start && (c == 2);
            if (busy_start && c == 2) begin
                mode_i        = ~mode;
                enable_mask_i = '1;
                timeout_i     = 8'd1;
            end
            if (c == 1) check({tag, "_busy_after_start"}, busy_o, 1);
            for (int j = 0; j < NC; j++) begin
                if (child_start_o[j]) begin
                    npulse[j]++;
                    if (obs_st[j] < 0) obs_st[j] = c;
                end
            end
            if (done_o) begin
                done_cyc = c;
                check({tag, "_error"}, error_o, exp_err);
                check({tag, "_done_mask"}, done_mask_o, exp_mask);
                check({tag, "_busy_at_done"}, busy_o, 0);
                if (exp_err) check({tag, "_fail_idx"}, fail_idx_o, exp_fidx);
            end
            child_done_i = (c == 2) ? spur : '0;
            for (int j = 0; j < NC; j++) begin
                if (obs_st[j] >= 0 && obs_st[j] + dly[j] == c) child_done_i[j] = 1'b1;
            end
        end
        child_done_i = '0;
        start_i      = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, exp_done);

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check({tag, "_no_start_after"}, child_start_o, 0);
            check({tag, "_single_done"}, done_o, 0);
            check({tag, "_error_held"}, error_o, exp_err);
            check({tag, "_mask_held"}, done_mask_o, exp_mask);
        end
        for (int j = 0; j < NC; j++) begin
            check($sformatf("%s_start_cycle%0d", tag, j), obs_st[j], exp_st[j]);
            check($sformatf("%s_pulses%0d", tag, j), npulse[j], (exp_st[j] >= 0) ? 1 : 0);
        end
    endtask

    initial begin
        int            d[NC];
        bit            m;
        logic [NC-1:0] msk;
        logic [TW-1:0] tmo;

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Sequential, all five children, three-cycle responders, no timeout.
        run_case("seq_all", 1'b0, 5'b11111, 8'd0, '{3, 3, 3, 3, 3}, '0, 1'b0);

        // Parallel on 4, 0, 2 answering at different times.
        run_case("par_mixed", 1'b1, 5'b10101, 8'd0, '{4, 1, 6, 1, 2}, '0, 1'b0);

        // Sequential timeout on an unresponsive child 1; child 2 must never start.
        run_case("seq_tmo", 1'b0, 5'b00110, 8'd4, '{1, NEVER, 1, 1, 1}, '0, 1'b0);

        // Empty mask, start while busy, spurious dones on disabled children.
        run_case("empty_seq", 1'b0, 5'b00000, 8'd0, '{1, 1, 1, 1, 1}, '0, 1'b0);
        run_case("empty_par", 1'b1, 5'b00000, 8'd3, '{1, 1, 1, 1, 1}, '0, 1'b0);
        run_case("busy_start", 1'b0, 5'b00011, 8'd0, '{3, 2, 1, 1, 1}, '0, 1'b1);
        run_case("spurious_par", 1'b1, 5'b00001, 8'd0, '{3, 1, 1, 1, 1}, 5'b01010, 1'b0);
        run_case("spurious_seq", 1'b0, 5'b10001, 8'd0, '{2, 1, 1, 1, 2}, 5'b00110, 1'b0);

        // Done on the expiry cycle succeeds; one cycle later it times out.
        run_case("tie_seq", 1'b0, 5'b00001, 8'd4, '{4, 1, 1, 1, 1}, '0, 1'b0);
        run_case("late_seq", 1'b0, 5'b00001, 8'd4, '{5, 1, 1, 1, 1}, '0, 1'b0);
        run_case("tie_par", 1'b1, 5'b01100, 8'd3, '{1, 1, 3, 2, 1}, '0, 1'b0);
        run_case("late_par", 1'b1, 5'b11010, 8'd3, '{1, 5, 1, 2, 7}, '0, 1'b0);

        // Reset in the middle of a wait.
        @(negedge clk);
        start_i       = 1'b1;
        mode_i        = 1'b0;
        enable_mask_i = 5'b00011;
        timeout_i     = 8'd0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_reset", busy_o, 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_reset_quiet_start", child_start_o, 0);
            check("post_reset_quiet_busy", busy_o, 0);
        end
        run_case("after_reset", 1'b0, 5'b00000, 8'd0, '{1, 1, 1, 1, 1}, '0, 1'b0);

        // Randomized runs against the reference outcome.
        for (int n = 0; n < 24; n++) begin
            m   = 1'($urandom_range(0, 1));
            msk = 5'($urandom_range(0, 31));
            tmo = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(2, 8));
            for (int j = 0; j < NC; j++) begin
                d[j] = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(1, 9));
            end
            if (tmo == 0) begin
                for (int j = 0; j < NC; j++) if (d[j] == NEVER) d[j] = 9;
            end
            run_case($sformatf("rand%0d", n), m, msk, tmo, d, '0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
